// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch interface for core_sequencer.
//
// Groups the request/accept/response handshake between the sequencer and the
// instruction memory:
//   imem_req    - fetch request, held by the sequencer until accepted
//   imem_addr   - fetch address (always the sequencer's current pc)
//   imem_ready  - memory accepts the request in a cycle where imem_req is high
//   imem_rvalid - instruction word on imem_rdata is valid this cycle
//   imem_rdata  - instruction word
// The sequencer connects through the master modport, memory models through
// the slave modport.
interface core_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for the npc core.
//
// Owns the pc, fetches one instruction at a time over the imem interface,
// presents it to the decode/execute datapath, pulses the register-file write
// enable in write-back and loads the datapath's next pc. Stops permanently on
// ebreak (halt) or on a fetch timeout / misaligned next pc (fault) until reset.
//
// Ports:
//   clk        - core clock, all state on rising edge
//   reset      - asynchronous active-low reset (0 = in reset)
//   imem       - instruction fetch handshake (master side)
//   inst       - latched current instruction word
//   inst_valid - high while the instruction is in EXEC or WB
//   exec_busy  - datapath requests more EXEC cycles
//   next_pc    - next pc from the datapath, sampled in WB
//   rf_wen     - register-file write enable, single-cycle pulse in WB
//   pc         - current pc
//   halt       - sticky, ebreak fetched
//   fault      - sticky, fetch timeout or misaligned next pc
//   instret    - retired-instruction counter (wraps)
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          MAX_WAIT = 16,
    parameter int          CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    core_sequencer_if.master      imem,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    input  logic                  exec_busy,
    input  logic [31:0]           next_pc,
    output logic                  rf_wen,
    output logic [31:0]           pc,
    output logic                  halt,
    output logic                  fault,
    output logic [CNT_W-1:0]      instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_R,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [7:0]  WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [7:0]         wait_q, wait_d;
    logic               imem_req_q, imem_req_d;
    logic               inst_valid_q, inst_valid_d;
    logic               rf_wen_q, rf_wen_d;
    logic               halt_q, halt_d;
    logic               fault_q, fault_d;

    // Stores, branches and writes to x0 never update the register file.
    function automatic logic writes_rd(input logic [11:0] low_bits);
        return (low_bits[11:7] != 5'd0) &&
               (low_bits[6:0] != OP_STORE) &&
               (low_bits[6:0] != OP_BRANCH);
    endfunction

    // Next-state logic. Outputs are derived from the next state so that they
    // come straight out of flops and track the state register exactly.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        wait_d    = wait_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // imem_req is always high in FETCH, so ready alone is the accept
                if (imem.imem_ready) begin
                    state_d = S_WAIT_R;
                    wait_d  = 8'd0;
                end
            end
            S_WAIT_R: begin
                // A response in the final wait cycle still beats the timeout
                if (imem.imem_rvalid) begin
                    inst_d = imem.imem_rdata;
                    if (imem.imem_rdata == EBREAK) begin
                        state_d   = S_HALT;
                        instret_d = instret_q + CNT_W'(1);
                    end else begin
                        state_d = S_EXEC;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (!exec_busy) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // A misaligned target leaves pc on the offending instruction
                if (next_pc[1:0] != 2'b00) begin
                    state_d = S_FAULT;
                end else begin
                    pc_d      = next_pc;
                    instret_d = instret_q + CNT_W'(1);
                    state_d   = S_FETCH;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        imem_req_d   = (state_d == S_FETCH);
        inst_valid_d = (state_d == S_EXEC) || (state_d == S_WB);
        rf_wen_d     = (state_d == S_WB) && writes_rd(inst_d[11:0]);
        halt_d       = (state_d == S_HALT);
        fault_d      = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            instret_q    <= '0;
            wait_q       <= 8'd0;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b0;
            rf_wen_q     <= 1'b0;
            halt_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            instret_q    <= instret_d;
            wait_q       <= wait_d;
            imem_req_q   <= imem_req_d;
            inst_valid_q <= inst_valid_d;
            rf_wen_q     <= rf_wen_d;
            halt_q       <= halt_d;
            fault_q      <= fault_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = inst_valid_q;
    assign rf_wen         = rf_wen_q;
    assign pc             = pc_q;
    assign halt           = halt_q;
    assign fault          = fault_q;
    assign instret        = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer.
//
// Drives the instruction memory and datapath side cycle by cycle from one
// initial block. The expected architectural state (pc, retired count, halt,
// fault, write-enable decision) comes from an instruction-level model that
// applies the sequencer's rules per fetched instruction.
module tb_core_sequencer;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          MAX_WAIT = 16;
    localparam int          CNT_W    = 32;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] ADDI     = 32'h0050_0093;

    logic              clk;
    logic              reset;
    logic [31:0]       inst;
    logic              inst_valid;
    logic              exec_busy;
    logic [31:0]       next_pc;
    logic              rf_wen;
    logic [31:0]       pc;
    logic              halt;
    logic              fault;
    logic [CNT_W-1:0]  instret;

    core_sequencer_if ifc ();

    core_sequencer #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (ifc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .exec_busy  (exec_busy),
        .next_pc    (next_pc),
        .rf_wen     (rf_wen),
        .pc         (pc),
        .halt       (halt),
        .fault      (fault),
        .instret    (instret)
    );

    int checks = 0;
    int errors = 0;

    // Instruction-level reference state
    logic [31:0] mPc;
    logic [31:0] mInstret;

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure with tag and values
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Asserts reset, checks the reset values, releases it on a falling edge
    // and confirms the single IDLE cycle hands over to FETCH.
    task automatic applyStimulus();
        ifc.imem_ready  = 1'b0;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = 32'd0;
        exec_busy       = 1'b0;
        next_pc         = 32'd0;
        reset           = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_req",     64'(ifc.imem_req), 64'(0));
        checkOutput("rst_pc",      64'(pc),           64'(RESET_PC));
        checkOutput("rst_addr",    64'(ifc.imem_addr), 64'(RESET_PC));
        checkOutput("rst_inst",    64'(inst),         64'(0));
        checkOutput("rst_instret", 64'(instret),      64'(0));
        checkOutput("rst_ivalid",  64'(inst_valid),   64'(0));
        checkOutput("rst_rfwen",   64'(rf_wen),       64'(0));
        checkOutput("rst_halt",    64'(halt),         64'(0));
        checkOutput("rst_fault",   64'(fault),        64'(0));
        reset    = 1'b1;
        mPc      = RESET_PC;
        mInstret = 32'd0;
        @(negedge clk);
        checkOutput("idle_exit_req", 64'(ifc.imem_req), 64'(1));
    endtask

    // Runs one instruction starting in FETCH. readyDelay cycles of ready low,
    // then rvalidDelay response-less wait cycles (>= MAX_WAIT means none),
    // then busyCycles of exec_busy, and the datapath offers npc in WB.
    task automatic runInstr(input logic [31:0] word, input int readyDelay, input int rvalidDelay,
                            input int busyCycles, input logic [31:0] npc, output int cycles);
        logic        expWen;
        logic [31:0] oldPc;
        cycles = 0;
        oldPc  = mPc;
        expWen = (word[11:7] != 5'd0) && (word[6:0] != 7'b0100011) && (word[6:0] != 7'b1100011);

        checkOutput("fetch_req",  64'(ifc.imem_req),  64'(1));
        checkOutput("fetch_addr", 64'(ifc.imem_addr), 64'(mPc));
        for (int i = 0; i < readyDelay; i++) begin
            ifc.imem_ready = 1'b0;
            @(negedge clk);
            cycles++;
            checkOutput("req_held", 64'(ifc.imem_req), 64'(1));
        end
        ifc.imem_ready = 1'b1;
        @(negedge clk);
        cycles++;
        ifc.imem_ready = 1'b0;
        checkOutput("wait_req_low", 64'(ifc.imem_req), 64'(0));

        if (rvalidDelay >= MAX_WAIT) begin
            repeat (MAX_WAIT - 1) begin
                @(negedge clk);
                cycles++;
            end
            checkOutput("no_early_fault", 64'(fault), 64'(0));
            @(negedge clk);
            cycles++;
            checkOutput("timeout_fault",   64'(fault),        64'(1));
            checkOutput("timeout_pc",      64'(pc),           64'(oldPc));
            checkOutput("timeout_instret", 64'(instret),      64'(mInstret));
            checkOutput("timeout_req",     64'(ifc.imem_req), 64'(0));
            return;
        end

        repeat (rvalidDelay) begin
            @(negedge clk);
            cycles++;
        end
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = word;
        next_pc         = npc;
        @(negedge clk);
        cycles++;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = $urandom();
        checkOutput("inst_latch", 64'(inst),  64'(word));
        checkOutput("no_fault",   64'(fault), 64'(0));

        if (word == EBREAK) begin
            mInstret = mInstret + 32'd1;
            checkOutput("halt_set",     64'(halt),         64'(1));
            checkOutput("halt_req",     64'(ifc.imem_req), 64'(0));
            checkOutput("halt_ivalid",  64'(inst_valid),   64'(0));
            checkOutput("halt_pc",      64'(pc),           64'(oldPc));
            checkOutput("halt_instret", 64'(instret),      64'(mInstret));
            return;
        end

        for (int j = 0; j <= busyCycles; j++) begin
            checkOutput("exec_ivalid", 64'(inst_valid), 64'(1));
            checkOutput("exec_rfwen",  64'(rf_wen),     64'(0));
            exec_busy = (j < busyCycles);
            @(negedge clk);
            cycles++;
        end
        exec_busy = 1'b0;

        checkOutput("wb_rfwen",  64'(rf_wen),     64'(expWen));
        checkOutput("wb_ivalid", 64'(inst_valid), 64'(1));
        @(negedge clk);
        cycles++;

        if (npc[1:0] != 2'b00) begin
            checkOutput("misalign_fault",   64'(fault),        64'(1));
            checkOutput("misalign_pc",      64'(pc),           64'(oldPc));
            checkOutput("misalign_instret", 64'(instret),      64'(mInstret));
            checkOutput("misalign_req",     64'(ifc.imem_req), 64'(0));
            checkOutput("misalign_rfwen",   64'(rf_wen),       64'(0));
        end else begin
            mPc      = npc;
            mInstret = mInstret + 32'd1;
            checkOutput("retire_pc",      64'(pc),           64'(mPc));
            checkOutput("retire_instret", 64'(instret),      64'(mInstret));
            checkOutput("refetch_req",    64'(ifc.imem_req), 64'(1));
            checkOutput("refetch_addr",   64'(ifc.imem_addr), 64'(mPc));
            checkOutput("rfwen_pulse",    64'(rf_wen),       64'(0));
            checkOutput("post_ivalid",    64'(inst_valid),   64'(0));
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] word;
        logic [31:0] npc;
        int          rdly;
        logic [31:0] heldPc;
        logic        reqSeen;
        logic        pcMoved;

        reset           = 1'b1;
        ifc.imem_ready  = 1'b0;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = 32'd0;
        exec_busy       = 1'b0;
        next_pc         = 32'd0;
        #1;

        // Single addi with minimum latency
        applyStimulus();
        runInstr(ADDI, 0, 0, 0, mPc + 32'd4, cyc);
        checkOutput("min_latency", 64'(cyc), 64'(4));
        checkOutput("first_pc",    64'(pc),  64'(32'h8000_0004));

        // Three back-to-back: stalled accept, then a long execute
        applyStimulus();
        runInstr(32'h0010_0113, 3, 0, 0, mPc + 32'd4, cyc);
        checkOutput("ready_stall_cycles", 64'(cyc), 64'(7));
        runInstr(32'h0020_0193, 0, 0, 5, mPc + 32'd4, cyc);
        checkOutput("exec_busy_cycles", 64'(cyc), 64'(9));
        runInstr(ADDI, 0, 1, 0, mPc + 32'd4, cyc);
        checkOutput("b2b_instret", 64'(instret), 64'(3));
        checkOutput("b2b_pc",      64'(pc),      64'(32'h8000_000C));

        // Store and branch never write the register file
        runInstr(32'h0011_2023, 0, 0, 0, mPc + 32'd4, cyc);
        runInstr(32'h0020_8463, 1, 2, 1, 32'h8000_0100, cyc);
        checkOutput("branch_pc", 64'(pc), 64'(32'h8000_0100));

        // Randomized instruction stream against the model
        for (int n = 0; n < 30; n++) begin
            word = $urandom();
            case ($urandom_range(0, 3))
                0: word[6:0]  = 7'b0100011;
                1: word[6:0]  = 7'b1100011;
                2: word[11:7] = 5'd0;
                default: ;
            endcase
            if (word == EBREAK) word[31] = 1'b1;
            rdly = ($urandom_range(0, 5) == 0) ? MAX_WAIT - 1 : int'($urandom_range(0, 4));
            npc  = ($urandom_range(0, 1) == 0) ? mPc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
            runInstr(word, int'($urandom_range(0, 3)), rdly, int'($urandom_range(0, 3)), npc, cyc);
        end

        // ebreak halts permanently and ignores further imem activity
        runInstr(EBREAK, 0, 0, 0, mPc + 32'd4, cyc);
        heldPc  = pc;
        reqSeen = 1'b0;
        pcMoved = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ifc.imem_ready  = 1'b1;
            ifc.imem_rvalid = 1'($urandom_range(0, 1));
            ifc.imem_rdata  = $urandom();
            @(negedge clk);
            if (ifc.imem_req) reqSeen = 1'b1;
            if (pc != heldPc) pcMoved = 1'b1;
        end
        ifc.imem_ready  = 1'b0;
        ifc.imem_rvalid = 1'b0;
        checkOutput("halt_no_req",   64'(reqSeen), 64'(0));
        checkOutput("halt_pc_held",  64'(pcMoved), 64'(0));
        checkOutput("halt_sticky",   64'(halt),    64'(1));
        checkOutput("halt_instret",  64'(instret), 64'(mInstret));

        // Fetch timeout, then response arriving in the very last wait cycle
        applyStimulus();
        runInstr(ADDI, 0, MAX_WAIT, 0, mPc + 32'd4, cyc);
        applyStimulus();
        runInstr(ADDI, 0, MAX_WAIT - 1, 0, mPc + 32'd4, cyc);
        checkOutput("late_rvalid_no_fault", 64'(fault), 64'(0));

        // Misaligned next pc faults and keeps the old pc
        runInstr(ADDI, 0, 0, 0, 32'h8000_0006, cyc);
        checkOutput("misalign_pc_value", 64'(pc), 64'(32'h8000_0004));

        // Asynchronous reset in the middle of WAIT_R
        applyStimulus();
        runInstr(ADDI, 0, 0, 0, mPc + 32'd4, cyc);
        ifc.imem_ready = 1'b1;
        @(negedge clk);
        ifc.imem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_pc",      64'(pc),           64'(RESET_PC));
        checkOutput("async_instret", 64'(instret),      64'(0));
        checkOutput("async_inst",    64'(inst),         64'(0));
        checkOutput("async_req",     64'(ifc.imem_req), 64'(0));
        checkOutput("async_ivalid",  64'(inst_valid),   64'(0));
        ifc.imem_rvalid = 1'b1;
        ifc.imem_rdata  = EBREAK;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("restart_addr",  64'(ifc.imem_addr), 64'(RESET_PC));
        checkOutput("restart_req",   64'(ifc.imem_req),  64'(1));
        checkOutput("idle_rv_halt",  64'(halt),          64'(0));
        checkOutput("idle_rv_inst",  64'(inst),          64'(0));
        ifc.imem_rvalid = 1'b0;
        mPc      = RESET_PC;
        mInstret = 32'd0;
        runInstr(ADDI, 0, 0, 0, mPc + 32'd4, cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
